// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 character LCD driver.
//   - step_e     : sequencer step index (INIT1..CHAR15, DONE = 24)
//   - CMD_*      : HD44780 command bytes used by the init sequence
//   - MSG        : fixed 16-character banner, character 0 in the top byte
//   - step_cfg() : RS / DB / length (in clk cycles) for each step
// Optional feature macro (used by lcd_display): LCD_DEBUG_STEP_EN.
package lcd_pkg;

  // Step lengths in clk cycles (10.24 us nominal period).
  localparam int T_INIT1 = 2000;
  localparam int T_INIT2 = 513;
  localparam int T_INIT3 = 150;
  localparam int T_CLEAR = 400;
  localparam int T_CHAR  = 10;
  localparam int E_HIGH  = 2;

  // Wide enough for the longest step (T_INIT1 - 1).
  localparam int CNT_W = 11;

  localparam logic [7:0] CMD_WAKE   = 8'h30;  // function set, 8-bit (wake-up)
  localparam logic [7:0] CMD_FSET   = 8'h38;  // 8-bit, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DOFF   = 8'h08;  // display off
  localparam logic [7:0] CMD_CLEAR  = 8'h01;  // clear display
  localparam logic [7:0] CMD_ENTRY  = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_DON    = 8'h0C;  // display on, cursor off

  localparam int MSG_LEN = 16;
  localparam logic [8*MSG_LEN-1:0] MSG = "ELEX 7660 LCD OK";

  typedef enum logic [4:0] {
    ST_INIT1  = 5'd0,
    ST_INIT2  = 5'd1,
    ST_INIT3  = 5'd2,
    ST_FSET   = 5'd3,
    ST_DOFF   = 5'd4,
    ST_CLR    = 5'd5,
    ST_ENTRY  = 5'd6,
    ST_DON    = 5'd7,
    ST_CHAR0  = 5'd8,
    ST_CHAR1  = 5'd9,
    ST_CHAR2  = 5'd10,
    ST_CHAR3  = 5'd11,
    ST_CHAR4  = 5'd12,
    ST_CHAR5  = 5'd13,
    ST_CHAR6  = 5'd14,
    ST_CHAR7  = 5'd15,
    ST_CHAR8  = 5'd16,
    ST_CHAR9  = 5'd17,
    ST_CHAR10 = 5'd18,
    ST_CHAR11 = 5'd19,
    ST_CHAR12 = 5'd20,
    ST_CHAR13 = 5'd21,
    ST_CHAR14 = 5'd22,
    ST_CHAR15 = 5'd23,
    ST_DONE   = 5'd24
  } step_e;

  typedef struct packed {
    logic             rs;
    logic [7:0]       db;
    logic [CNT_W-1:0] len;
  } step_cfg_t;

  // DONE returns RS=0/DB=0; its length is irrelevant because the timer is
  // held idle there.
  function automatic step_cfg_t step_cfg(input step_e s);
    step_cfg_t c;
    int        idx;
    c.rs  = 1'b0;
    c.db  = 8'h00;
    c.len = CNT_W'(1);
    idx   = 0;
    case (s)
      ST_INIT1: begin c.db = CMD_WAKE;  c.len = CNT_W'(T_INIT1); end
      ST_INIT2: begin c.db = CMD_WAKE;  c.len = CNT_W'(T_INIT2); end
      ST_INIT3: begin c.db = CMD_WAKE;  c.len = CNT_W'(T_INIT3); end
      ST_FSET:  begin c.db = CMD_FSET;  c.len = CNT_W'(T_INIT3); end
      ST_DOFF:  begin c.db = CMD_DOFF;  c.len = CNT_W'(T_INIT3); end
      ST_CLR:   begin c.db = CMD_CLEAR; c.len = CNT_W'(T_CLEAR); end
      ST_ENTRY: begin c.db = CMD_ENTRY; c.len = CNT_W'(T_INIT3); end
      ST_DON:   begin c.db = CMD_DON;   c.len = CNT_W'(T_INIT3); end
      ST_DONE:  ;
      default: begin
        // CHAR0..CHAR15: character i sits in the top-down byte i of MSG.
        idx   = int'(s) - int'(ST_CHAR0);
        c.rs  = 1'b1;
        c.db  = 8'(MSG >> (8 * (MSG_LEN - 1 - idx)));
        c.len = CNT_W'(T_CHAR);
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// lcd_strobe_timer: per-step cycle counter and E strobe generator.
//   clk, rst   : clock, async active-high reset
//   run        : step active; when low the counter is held at 0 and E is low
//   len        : step length N in cycles (counter runs 0..N-1)
//   e          : registered E strobe, high while counter in [N/2, N/2+E_HIGH)
//   step_done  : combinational, high in the cycle the counter is at N-1
// E is registered from the same counter value the sequencer uses to register
// RS/DB, so strobe and bus stay cycle-aligned at the pins.
module lcd_strobe_timer
  import lcd_pkg::*;
#(
  parameter int E_HIGH_P = E_HIGH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] len,
  output logic             e,
  output logic             step_done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half;
  logic             e_q, e_d;

  always_comb begin
    half      = len >> 1;
    step_done = run && (cnt_q == len - CNT_W'(1));
    e_d       = run && (cnt_q >= half) && (cnt_q < half + CNT_W'(E_HIGH_P));
    cnt_d     = cnt_q + CNT_W'(1);
    if (!run || step_done) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      e_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      e_q   <= e_d;
    end
  end

  assign e = e_q;

endmodule

// File: rtl/lcd_display.sv
// lcd_display: autonomous HD44780 power-on init + fixed message writer.
//   clk   : system clock (10.24 us nominal)
//   rst   : async active-high reset; restarts the sequence at INIT1
//   RS    : register select (0 command, 1 data), registered
//   RW    : always 0 (write-only)
//   E     : enable strobe, registered, LCD latches on falling edge
//   data  : [7:0] DB7..DB0, [12:8] debug step index
// Build option LCD_DEBUG_STEP_EN: when defined, data[12:8] carries the
// current step index (DONE = 24); otherwise data[12:8] is held at 0.
module lcd_display
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        RS,
  output logic        RW,
  output logic        E,
  output logic [12:0] data
);

  step_e      step_q, step_d;
  logic       rs_q, rs_d;
  logic [7:0] db_q, db_d;
  logic [4:0] dbg_q, dbg_d;
  step_cfg_t  cfg;
  logic       run;
  logic       step_done;
  logic       e_w;

  lcd_strobe_timer #(.E_HIGH_P(E_HIGH)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .len       (cfg.len),
    .e         (e_w),
    .step_done (step_done)
  );

  // RS/DB are registered from the current step so they change on the same
  // edge the timer's counter restarts at 0 for that step.
  always_comb begin
    cfg    = step_cfg(step_q);
    run    = (step_q != ST_DONE);
    step_d = step_q;
    if (step_done) step_d = step_e'(step_q + 5'd1);
    rs_d   = cfg.rs;
    db_d   = cfg.db;
`ifdef LCD_DEBUG_STEP_EN
    dbg_d  = step_q;
`else
    dbg_d  = 5'd0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= ST_INIT1;
      rs_q   <= 1'b0;
      db_q   <= 8'h00;
      dbg_q  <= 5'd0;
    end else begin
      step_q <= step_d;
      rs_q   <= rs_d;
      db_q   <= db_d;
      dbg_q  <= dbg_d;
    end
  end

  assign RS   = rs_q;
  assign RW   = 1'b0;
  assign E    = e_w;
  assign data = {dbg_q, db_q};

endmodule

// File: tb/tb_lcd_display.sv
// Directed bench for lcd_display: reset behaviour, INIT strobe timing,
// strobe width / bus stability, command+character order, termination and
// mid-sequence reset. Cycle c is the c-th rising edge after rst release;
// outputs are sampled on the falling edge that follows it.
module tb_lcd_display;

  logic        clk;
  logic        rst;
  logic        RS, RW, E;
  logic [12:0] data;

  lcd_display dut (
    .clk  (clk),
    .rst  (rst),
    .RS   (RS),
    .RW   (RW),
    .E    (E),
    .data (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [4:0] dbg(input int s);
`ifdef LCD_DEBUG_STEP_EN
    return 5'(s);
`else
    return 5'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  // Release on a falling edge so the next rising edge is cycle 0.
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
  endtask

  // ---------------- strobe monitor ----------------
  logic       e_prev    = 1'b0;
  logic       post_fall = 1'b0;
  int         width     = 0;
  int         rises     = 0;
  logic       rw_bad    = 1'b0;
  logic [7:0] db_r;
  logic       rs_r;
  logic [8:0] log_q[$];

  always @(negedge clk) begin
    if (RW !== 1'b0) rw_bad = 1'b1;
    if (rst) begin
      e_prev    = 1'b0;
      post_fall = 1'b0;
      width     = 0;
      log_q.delete();
    end else begin
      if (E && !e_prev) begin
        rises++;
        width = 1;
        db_r  = data[7:0];
        rs_r  = RS;
      end else begin
        if (E) width++;
        if (E || e_prev || post_fall) begin
          chk("db_stable", {24'd0, data[7:0]}, {24'd0, db_r});
          chk("rs_stable", {31'd0, RS}, {31'd0, rs_r});
        end
      end
      if (!E && e_prev) begin
        chk("e_width", width, 2);
        log_q.push_back({RS, data[7:0]});
      end
      post_fall = !E && e_prev;
      e_prev    = E;
    end
  end

  // ---------------- directed sequence ----------------
  logic [8:0] exp_tab[24];
  string      msg = "ELEX 7660 LCD OK";
  int         r0;

  initial begin
    exp_tab[0] = 9'h030; exp_tab[1] = 9'h030; exp_tab[2] = 9'h030;
    exp_tab[3] = 9'h038; exp_tab[4] = 9'h008; exp_tab[5] = 9'h001;
    exp_tab[6] = 9'h006; exp_tab[7] = 9'h00C;
    for (int i = 0; i < 16; i++) exp_tab[8+i] = {1'b1, msg[i]};

    // Reset toggling: 1 -> 0 -> 1 -> 0, 20 cycles each.
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_E", E, 0);
    chk("rst_RS", RS, 0);
    chk("rst_RW", RW, 0);
    chk("rst_data", data, 0);
    release_rst();
    go(19);
    chk("run1_data", data, {dbg(0), 8'h30});
    chk("run1_E", E, 0);
    rst = 1'b1;
    #1;
    chk("rst2_async_data", data, 0);
    chk("rst2_async_RS", RS, 0);
    repeat (20) @(negedge clk);
    chk("rst2_E", E, 0);
    chk("rst2_data", data, 0);
    release_rst();

    // INIT strobes.
    go(0);
    chk("c0_data", data, {dbg(0), 8'h30});
    chk("c0_E", E, 0);
    go(999);  chk("c999_E", E, 0);
    go(1000); chk("c1000_E", E, 1); chk("c1000_data", data, {dbg(0), 8'h30});
    chk("c1000_RS", RS, 0);
    go(1001); chk("c1001_E", E, 1);
    go(1002); chk("c1002_E", E, 0);
    go(2255); chk("c2255_E", E, 0);
    go(2256); chk("c2256_E", E, 1); chk("c2256_data", data, {dbg(1), 8'h30});
    go(2587); chk("c2587_E", E, 0);
    go(2588); chk("c2588_E", E, 1); chk("c2588_data", data, {dbg(2), 8'h30});

    // Last character, then DONE.
    go(3822);
    chk("c3822_RS", RS, 1);
    chk("c3822_db", data[7:0], 8'h4B);
    go(3823);
    chk("done_data", data, {dbg(24), 8'h00});
    chk("done_RS", RS, 0);
    chk("done_E", E, 0);

    // Command / character order as latched on E falling edges.
    chk("log_size", log_q.size(), 24);
    for (int i = 0; i < 24; i++)
      if (i < log_q.size()) chk($sformatf("latch%0d", i), log_q[i], exp_tab[i]);

    // Termination.
    r0 = rises;
    go(3823 + 3000);
    chk("idle_rises", rises, r0);
    chk("idle_E", E, 0);
    chk("idle_data", data, {dbg(24), 8'h00});
    chk("rw_never", rw_bad, 0);

    // Reset mid-character (CHAR5 = '7').
    rst = 1'b1;
    @(negedge clk);
    release_rst();
    go(3715);
    chk("char5_db", data, {dbg(13), 8'h37});
    chk("char5_RS", RS, 1);
    rst = 1'b1;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_RS", RS, 0);
    chk("midrst_E", E, 0);
    repeat (5) @(negedge clk);
    release_rst();
    go(999);  chk("re_c999_E", E, 0);
    go(1000); chk("re_c1000_E", E, 1);
    chk("re_c1000_data", data, {dbg(0), 8'h30});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
